// File: rtl/vga_pkg.sv
// Shared VGA text-mode constants and menu controller types.
// Character codes follow the 7-bit text ROM layout.
package vga_pkg;

  localparam logic [6:0] SPACE       = 7'h20;
  localparam logic [6:0] MARKER_CHAR = 7'h10;

  typedef enum logic [0:0] {
    MENU = 1'b0,
    ITEM = 1'b1
  } menu_state_t;

endpackage

// File: rtl/game_menu_ctl_if.sv
// Char path between draw stage, menu controller and text ROM.
// The controller sits on the slave side of this bundle.
interface game_menu_ctl_if;

  logic [7:0] char_xy_in;
  logic [7:0] char_xy_rom;
  logic [6:0] char_rom_code;
  logic [6:0] char_code;

  modport master (
    output char_xy_in,
    output char_rom_code,
    input  char_xy_rom,
    input  char_code
  );

  modport slave (
    input  char_xy_in,
    input  char_rom_code,
    output char_xy_rom,
    output char_code
  );

endinterface

// File: rtl/game_menu_ctl_debounce.sv
// Button synchronizer and debouncer producing one pulse per press.
// Accepted level resets high so a button held through reset is ignored.
module btn_debounce #(
  parameter int DEB_CYC = 650_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Sync, count consecutive differing samples, accept and pulse on rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      level       <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_raw};
      press_pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level       <= sync[1];
        cnt         <= '0;
        press_pulse <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_menu_ctl.sv
// Main-menu controller: button FSM, cursor tracking and marker
// column overlay on the text ROM path.
module game_menu_ctl
  import vga_pkg::*;
#(
  parameter int         N_ITEMS  = 4,
  parameter logic [3:0] MARK_COL = 4'h1,
  parameter int         DEB_CYC  = 650_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            btn_enter,
  input  logic            btn_back,
  game_menu_ctl_if.slave  bus,
  output logic [3:0]      cursor_row,
  output logic [3:0]      item_sel,
  output logic            item_valid,
  output logic            menu_active
);

  localparam logic [3:0] LAST_ROW = 4'(N_ITEMS - 1);
  localparam logic [4:0] ROWS     = 5'(N_ITEMS);

  logic p_up, p_down, p_enter, p_back;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .press_pulse(p_up));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_down (
    .clk(clk), .rst(rst), .btn_raw(btn_down), .press_pulse(p_down));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_enter (
    .clk(clk), .rst(rst), .btn_raw(btn_enter), .press_pulse(p_enter));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_back (
    .clk(clk), .rst(rst), .btn_raw(btn_back), .press_pulse(p_back));

  menu_state_t state, state_n;
  logic [3:0]  cur_n, sel_n;
  logic        vld_n;
  logic [7:0]  xy_q;

  // State, cursor and selection registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MENU;
      cursor_row <= 4'd0;
      item_sel   <= 4'd0;
      item_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cursor_row <= cur_n;
      item_sel   <= sel_n;
      item_valid <= vld_n;
    end
  end

  // Next state: enter beats up/down, opposing moves cancel.
  always_comb begin
    state_n = state;
    cur_n   = cursor_row;
    sel_n   = item_sel;
    vld_n   = 1'b0;
    unique case (state)
      MENU: begin
        if (p_enter) begin
          state_n = ITEM;
          sel_n   = cursor_row;
          vld_n   = 1'b1;
        end else if (p_up && !p_down) begin
          cur_n = (cursor_row == 4'd0) ? LAST_ROW
                                       : cursor_row - 4'd1;
        end else if (p_down && !p_up) begin
          cur_n = (cursor_row == LAST_ROW) ? 4'd0
                                           : cursor_row + 4'd1;
        end
      end
      ITEM: begin
        if (p_back) state_n = MENU;
      end
      default: state_n = MENU;
    endcase
  end

  assign menu_active = (state == MENU);

  // Address delayed to line up with ROM data.
  always_ff @(posedge clk) begin
    if (rst) xy_q <= 8'd0;
    else     xy_q <= bus.char_xy_in;
  end

  assign bus.char_xy_rom = bus.char_xy_in;

  // Marker column overlay on selectable rows.
  always_comb begin
    bus.char_code = bus.char_rom_code;
    if (xy_q[3:0] == MARK_COL && {1'b0, xy_q[7:4]} < ROWS) begin
      bus.char_code = (xy_q[7:4] == cursor_row) ? MARKER_CHAR
                                                : SPACE;
    end
  end

endmodule

// File: tb/tb_game_menu_ctl.sv
// Scoreboard bench for game_menu_ctl with short debounce.
// Monitor pops expected values whenever outputs change or pulse.
module tb_game_menu_ctl;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0;
  logic btn_enter = 1'b0, btn_back = 1'b0;
  logic [3:0] cursor_row, item_sel;
  logic       item_valid, menu_active;

  game_menu_ctl_if bus ();

  game_menu_ctl #(.N_ITEMS(4), .MARK_COL(4'h1), .DEB_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_enter(btn_enter), .btn_back(btn_back),
    .bus(bus),
    .cursor_row(cursor_row), .item_sel(item_sel),
    .item_valid(item_valid), .menu_active(menu_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] cur_q[$];
  logic       menu_q[$];
  logic [3:0] item_q[$];
  logic [6:0] char_q[$];

  logic       mon_en = 1'b0;
  logic       char_req = 1'b0;
  logic       char_vld = 1'b0;
  logic [3:0] prev_cur;
  logic       prev_menu;

  function automatic logic [6:0] rom_fn(input logic [7:0] xy);
    if (xy == 8'h34) return 7'h53;
    return {1'b1, xy[5:0]};
  endfunction

  // Text ROM model: one cycle read latency.
  initial bus.char_xy_in = 8'h00;
  always @(posedge clk) begin
    bus.char_rom_code <= rom_fn(bus.char_xy_rom);
    char_vld <= char_req;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every output event against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cursor_row !== prev_cur) begin
        if (cur_q.size() > 0) check("cursor", cursor_row, cur_q.pop_front());
        else check("cursor_unexpected", cursor_row, prev_cur);
      end
      if (menu_active !== prev_menu) begin
        if (menu_q.size() > 0) check("menu_active", menu_active, menu_q.pop_front());
        else check("menu_unexpected", menu_active, prev_menu);
      end
      if (item_valid) begin
        if (item_q.size() > 0) check("item_sel", item_sel, item_q.pop_front());
        else check("item_valid_unexpected", item_valid, 0);
      end
      if (char_vld) begin
        if (char_q.size() > 0) check("char_code", bus.char_code, char_q.pop_front());
        else check("char_unexpected", char_vld, 0);
      end
      prev_cur  = cursor_row;
      prev_menu = menu_active;
    end
  end

  // mask bits: 0 up, 1 down, 2 enter, 3 back
  task automatic press(input logic [3:0] mask, input int hold);
    @(negedge clk);
    btn_up    = mask[0];
    btn_down  = mask[1];
    btn_enter = mask[2];
    btn_back  = mask[3];
    repeat (hold) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0;
    btn_enter = 1'b0; btn_back = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic chk_char(input logic [7:0] xy, input logic [6:0] exp);
    @(negedge clk);
    bus.char_xy_in = xy;
    char_q.push_back(exp);
    char_req = 1'b1;
    @(negedge clk);
    char_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cursor", cursor_row, 0);
    check("rst_item_sel", item_sel, 0);
    check("rst_item_valid", item_valid, 0);
    check("rst_menu_active", menu_active, 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    prev_cur  = cursor_row;
    prev_menu = menu_active;
    mon_en    = 1'b1;

    // 1: two downs, then marker column reads
    cur_q.push_back(4'd1); press(4'b0010, 10);
    cur_q.push_back(4'd2); press(4'b0010, 10);
    chk_char(8'h21, MARKER_CHAR);
    chk_char(8'h01, SPACE);
    chk_char(8'h22, rom_fn(8'h22));
    chk_char(8'h41, rom_fn(8'h41));

    // 2: wrap both directions
    cur_q.push_back(4'd3); press(4'b0010, 10);
    cur_q.push_back(4'd0); press(4'b0010, 10);
    cur_q.push_back(4'd3); press(4'b0001, 10);
    cur_q.push_back(4'd0); press(4'b0010, 10);

    // 3: glitch ignored, long hold gives one step
    press(4'b0010, 2);
    cur_q.push_back(4'd1); press(4'b0010, 100);
    check("hold_cursor", cursor_row, 1);

    // 4: enter, ignored down, back
    item_q.push_back(4'd1); menu_q.push_back(1'b0);
    press(4'b0100, 10);
    check("item_sel_hold", item_sel, 1);
    press(4'b0010, 10);
    menu_q.push_back(1'b1); press(4'b1000, 10);
    check("back_cursor", cursor_row, 1);

    // 5: up+down cancel, enter beats down
    press(4'b0011, 10);
    item_q.push_back(4'd1); menu_q.push_back(1'b0);
    press(4'b0110, 10);

    // 6: plain ROM char, then reset from ITEM
    chk_char(8'h34, 7'h53);
    cur_q.push_back(4'd0); menu_q.push_back(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_item_sel2", item_sel, 0);
    check("rst_item_valid2", item_valid, 0);
    repeat (10) @(negedge clk);

    check("cur_q_empty", cur_q.size(), 0);
    check("menu_q_empty", menu_q.size(), 0);
    check("item_q_empty", item_q.size(), 0);
    check("char_q_empty", char_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
